// File: rtl/hci_mem_pkg.sv
// Shared constants and address helper for the HCI memory bank adapter.
package hci_mem_pkg;

  localparam logic HCI_OPC_OK  = 1'b0;
  localparam logic HCI_OPC_ERR = 1'b1;

  // Full-width word index; callers truncate to their SRAM address width.
  function automatic logic [63:0] word_idx(input logic [63:0] add,
                                           input logic [63:0] base,
                                           input int unsigned data_width);
    return (add - base) >> $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/hci_core_intf.sv
// HCI core request/response bundle with initiator and target views.
interface hci_core_intf #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 32,
  parameter int unsigned UW = 1,
  parameter int unsigned IW = 8,
  parameter int unsigned EW = 1
);
  logic          req;
  logic          gnt;
  logic [AW-1:0] add;
  logic          wen;
  logic [DW-1:0] data;
  logic [DW/8-1:0] be;
  logic [UW-1:0] user;
  logic [IW-1:0] id;
  logic [EW-1:0] ecc;
  logic          ereq;
  logic          egnt;
  logic [DW-1:0] r_data;
  logic          r_valid;
  logic          r_ready;
  logic [UW-1:0] r_user;
  logic [IW-1:0] r_id;
  logic          r_opc;
  logic [EW-1:0] r_ecc;
  logic          r_evalid;
  logic          r_eready;

  modport initiator (
    output req, add, wen, data, be, user, id, ecc, ereq, r_ready, r_eready,
    input  gnt, egnt, r_data, r_valid, r_user, r_id, r_opc, r_ecc, r_evalid
  );

  modport target (
    input  req, add, wen, data, be, user, id, ecc, ereq, r_ready, r_eready,
    output gnt, egnt, r_data, r_valid, r_user, r_id, r_opc, r_ecc, r_evalid
  );

endinterface

// File: rtl/hci_mem_resp_fifo.sv
// Response buffer: Depth entries, registered pointers, combinational head read.
// Push while full is only legal together with a pop.
module hci_mem_resp_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 2,
  localparam int unsigned CntW = $clog2(Depth + 1),
  localparam int unsigned PtrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CntW-1:0]  usage
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;

  function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full  = (usage == CntW'(Depth));
  assign empty = (usage == '0);
  assign rdata = mem_q[rptr_q];

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= wdata;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      usage  <= '0;
    end else begin
      assert (!(push && full && !pop));
      assert (!(pop && empty));
      if (push) wptr_q <= ptr_next(wptr_q);
      if (pop)  rptr_q <= ptr_next(rptr_q);
      case ({push, pop})
        2'b10:   usage <= usage + CntW'(1);
        2'b01:   usage <= usage - CntW'(1);
        default: usage <= usage;
      endcase
    end
  end

endmodule

// File: rtl/hci_mem_bank_adapter.sv
// HCI target -> 1-cycle SRAM; response one cycle after grant, credit-limited so r_ready stalls never drop data.
// Define HCI_MEM_ADDR_CHECK_EN to flag out-of-range accesses with r_opc=1 and suppress their SRAM strobe.
module hci_mem_bank_adapter
  import hci_mem_pkg::*;
#(
  parameter int unsigned          NumWords  = 1024,
  parameter int unsigned          DataWidth = 32,
  parameter int unsigned          AddrWidth = 32,
  parameter logic [AddrWidth-1:0] BaseAddr  = '0,
  parameter int unsigned          RespDepth = 2,
  parameter int unsigned          IdWidth   = 8,
  parameter int unsigned          UserWidth = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  hci_core_intf.target                 tcdm_slave,
  output logic                         sram_req_o,
  output logic                         sram_we_o,
  output logic [$clog2(NumWords)-1:0]  sram_addr_o,
  output logic [DataWidth-1:0]         sram_wdata_o,
  output logic [DataWidth/8-1:0]       sram_be_o,
  input  logic [DataWidth-1:0]         sram_rdata_i
);

  localparam int unsigned SramAw = $clog2(NumWords);
  localparam int unsigned CntW   = $clog2(RespDepth + 1);

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [IdWidth-1:0]   id;
    logic [UserWidth-1:0] user;
    logic                 opc;
  } resp_t;

  logic [63:0]          widx;
  logic                 addr_err;
  logic                 gnt;
  logic [CntW:0]        credit;
  logic                 inflight_q;
  logic                 tag_read_q;
  logic                 tag_err_q;
  logic [IdWidth-1:0]   tag_id_q;
  logic [UserWidth-1:0] tag_user_q;
  resp_t                direct, head, resp;
  logic                 r_valid;
  logic                 push, pop;
  logic                 full, empty;
  logic [CntW-1:0]      usage;

  assign widx = word_idx(64'(tcdm_slave.add), 64'(BaseAddr), DataWidth);

`ifdef HCI_MEM_ADDR_CHECK_EN
  assign addr_err = (tcdm_slave.add < BaseAddr) || (widx >= 64'(NumWords));
`else
  assign addr_err = 1'b0;
`endif

  // Grant ignores r_ready and same-cycle pops so it never depends on the response path.
  assign credit = (CntW+1)'(usage) + (CntW+1)'(inflight_q);
  assign gnt    = rst_ni & tcdm_slave.req & (credit < (CntW+1)'(RespDepth));

  assign sram_req_o   = gnt & ~addr_err;
  assign sram_we_o    = sram_req_o & ~tcdm_slave.wen;
  assign sram_addr_o  = widx[SramAw-1:0];
  assign sram_wdata_o = tcdm_slave.data;
  assign sram_be_o    = tcdm_slave.be;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      inflight_q <= 1'b0;
      tag_read_q <= 1'b0;
      tag_err_q  <= 1'b0;
      tag_id_q   <= '0;
      tag_user_q <= '0;
    end else begin
      inflight_q <= gnt;
      if (gnt) begin
        tag_read_q <= tcdm_slave.wen;
        tag_err_q  <= addr_err;
        tag_id_q   <= tcdm_slave.id;
        tag_user_q <= tcdm_slave.user;
      end
    end
  end

  always_comb begin
    direct      = '0;
    direct.data = (tag_read_q && !tag_err_q) ? sram_rdata_i : '0;
    direct.id   = tag_id_q;
    direct.user = tag_user_q;
    direct.opc  = tag_err_q ? HCI_OPC_ERR : HCI_OPC_OK;
  end

  // SRAM read data lives for one cycle only, so an unconsumed response is parked in the buffer.
  assign r_valid = inflight_q | ~empty;
  assign push    = inflight_q & (~empty | ~tcdm_slave.r_ready);
  assign pop     = tcdm_slave.r_ready & ~empty;
  assign resp    = !r_valid ? '0 : (empty ? direct : head);

  hci_mem_resp_fifo #(
    .Width ($bits(resp_t)),
    .Depth (RespDepth)
  ) u_resp_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (push),
    .wdata  (direct),
    .pop    (pop),
    .rdata  (head),
    .full   (full),
    .empty  (empty),
    .usage  (usage)
  );

  assign tcdm_slave.gnt      = gnt;
  assign tcdm_slave.r_valid  = r_valid;
  assign tcdm_slave.r_data   = resp.data;
  assign tcdm_slave.r_id     = resp.id;
  assign tcdm_slave.r_user   = resp.user;
  assign tcdm_slave.r_opc    = resp.opc;
  assign tcdm_slave.egnt     = 1'b0;
  assign tcdm_slave.r_evalid = 1'b0;
  assign tcdm_slave.r_ecc    = '0;

  logic unused_sig;
  assign unused_sig = ^{widx[63:SramAw], full, tcdm_slave.ereq, tcdm_slave.r_eready, tcdm_slave.ecc};

endmodule

// File: tb/tb_hci_mem_bank_adapter.sv
// Directed bench for hci_mem_bank_adapter with a behavioural 1-cycle SRAM.
module tb_hci_mem_bank_adapter;

  localparam int unsigned NW   = 16;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hci_core_intf #(.DW(32), .AW(32), .UW(2), .IW(8), .EW(1)) tcdm ();

  logic        sram_req, sram_we;
  logic [3:0]  sram_addr;
  logic [31:0] sram_wdata, sram_rdata;
  logic [3:0]  sram_be;
  logic [31:0] mem [NW];

  hci_mem_bank_adapter #(
    .NumWords (NW), .DataWidth (32), .AddrWidth (32), .BaseAddr (BASE),
    .RespDepth (2), .IdWidth (8), .UserWidth (2)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .tcdm_slave   (tcdm),
    .sram_req_o   (sram_req),
    .sram_we_o    (sram_we),
    .sram_addr_o  (sram_addr),
    .sram_wdata_o (sram_wdata),
    .sram_be_o    (sram_be),
    .sram_rdata_i (sram_rdata)
  );

  always @(posedge clk) begin
    if (sram_req) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic wen, input logic [31:0] add,
                       input logic [31:0] data, input logic [3:0] be, input logic [7:0] id);
    @(negedge clk);
    tcdm.req  = r;
    tcdm.wen  = wen;
    tcdm.add  = add;
    tcdm.data = data;
    tcdm.be   = be;
    tcdm.id   = id;
    tcdm.user = id[1:0];
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b1, BASE, 32'h0, 4'h0, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k, grants, got, sg, sr;
    for (int i = 0; i < int'(NW); i++) mem[i] = 32'h0;
    sram_rdata    = 32'h0;
    tcdm.ecc      = '0;
    tcdm.ereq     = 1'b0;
    tcdm.r_eready = 1'b0;
    tcdm.r_ready  = 1'b1;
    tcdm.req      = 1'b0;

    // Reset: request asserted must not be granted
    drive(1'b1, 1'b0, BASE, 32'h1234_5678, 4'hF, 8'h07);
    check("rst_gnt",      64'(tcdm.gnt),     64'h0);
    check("rst_sram_req", 64'(sram_req),     64'h0);
    check("rst_sram_we",  64'(sram_we),      64'h0);
    check("rst_r_valid",  64'(tcdm.r_valid), 64'h0);
    check("rst_r_data",   64'(tcdm.r_data),  64'h0);
    check("rst_r_id",     64'(tcdm.r_id),    64'h0);
    check("rst_r_user",   64'(tcdm.r_user),  64'h0);
    check("rst_r_opc",    64'(tcdm.r_opc),   64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tcdm.req = 1'b0;

    // Single write then read of word 4
    drive(1'b1, 1'b0, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 8'h01);
    check("wr_gnt",       64'(tcdm.gnt),   64'h1);
    check("wr_sram_req",  64'(sram_req),   64'h1);
    check("wr_sram_we",   64'(sram_we),    64'h1);
    check("wr_sram_addr", 64'(sram_addr),  64'h4);
    check("wr_sram_be",   64'(sram_be),    64'hF);
    drive(1'b1, 1'b1, BASE + 32'h10, 32'h0, 4'hF, 8'h02);
    check("wr_rsp_valid", 64'(tcdm.r_valid), 64'h1);
    check("wr_rsp_id",    64'(tcdm.r_id),    64'h1);
    check("wr_rsp_data",  64'(tcdm.r_data),  64'h0);
    check("wr_mem4",      64'(mem[4]),       64'hDEAD_BEEF);
    check("rd_gnt",       64'(tcdm.gnt),     64'h1);
    check("rd_sram_we",   64'(sram_we),      64'h0);
    idle();
    check("rd_rsp_valid", 64'(tcdm.r_valid), 64'h1);
    check("rd_rsp_data",  64'(tcdm.r_data),  64'hDEAD_BEEF);
    check("rd_rsp_id",    64'(tcdm.r_id),    64'h2);
    check("rd_rsp_user",  64'(tcdm.r_user),  64'h2);
    check("rd_rsp_opc",   64'(tcdm.r_opc),   64'h0);
    idle();
    check("rd_done_valid", 64'(tcdm.r_valid), 64'h0);

    // Byte enables over all-ones
    drive(1'b1, 1'b0, BASE + 32'h20, 32'hFFFF_FFFF, 4'hF, 8'h03);
    drive(1'b1, 1'b0, BASE + 32'h20, 32'h1122_3344, 4'h5, 8'h04);
    drive(1'b1, 1'b1, BASE + 32'h20, 32'h0, 4'hF, 8'h05);
    idle();
    check("be_rsp_data", 64'(tcdm.r_data), 64'hFF22_FF44);
    check("be_rsp_id",   64'(tcdm.r_id),   64'h5);

    // Backpressure: preload words 0..4 with A0+k, then 5 reads with r_ready low
    for (int j = 0; j < 5; j++)
      drive(1'b1, 1'b0, BASE + 32'(4 * j), 32'hA0 + 32'(j), 4'hF, 8'(20 + j));
    idle();
    idle();
    k = 0; grants = 0; got = 0;
    for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
      @(negedge clk);
      tcdm.r_ready = (cyc >= 6);
      tcdm.req     = (k < 5);
      tcdm.wen     = 1'b1;
      tcdm.add     = BASE + 32'(4 * k);
      tcdm.be      = 4'hF;
      tcdm.id      = 8'(10 + k);
      tcdm.user    = 2'(k);
      #1;
      if (cyc == 3) begin
        check("bp_stall_valid", 64'(tcdm.r_valid), 64'h1);
        check("bp_stall_id",    64'(tcdm.r_id),    64'd10);
      end
      if (cyc == 5) begin
        check("bp_stall_gnt",    64'(tcdm.gnt),    64'h0);
        check("bp_stall_grants", 64'(grants),      64'd2);
        check("bp_stall_data",   64'(tcdm.r_data), 64'hA0);
      end
      if (tcdm.gnt) begin
        grants++;
        k++;
      end
      if (tcdm.r_valid && tcdm.r_ready) begin
        check("bp_rsp_id",   64'(tcdm.r_id),   64'(10 + got));
        check("bp_rsp_data", 64'(tcdm.r_data), 64'(32'hA0 + 32'(got)));
        got++;
      end
    end
    check("bp_total_grants", 64'(grants), 64'd5);
    check("bp_total_rsps",   64'(got),    64'd5);
    tcdm.r_ready = 1'b1;
    idle();
    idle();

    // Streaming: even i writes 5000+i to word (i/2)%16, odd i reads it back
    sg = 0; sr = 0;
    for (int i = 0; i < 65; i++) begin
      @(negedge clk);
      tcdm.req  = (i < 64);
      tcdm.wen  = (i % 2 == 1);
      tcdm.add  = BASE + 32'(4 * ((i / 2) % 16));
      tcdm.data = 32'h5000 + 32'(i);
      tcdm.be   = 4'hF;
      tcdm.id   = 8'(i);
      tcdm.user = 2'(i);
      #1;
      if (i < 64) begin
        check("st_gnt", 64'(tcdm.gnt), 64'h1);
        if (tcdm.gnt) sg++;
      end
      if (i > 0) begin
        check("st_rsp_valid", 64'(tcdm.r_valid), 64'h1);
        check("st_rsp_id",    64'(tcdm.r_id),    64'(i - 1));
        check("st_rsp_data",  64'(tcdm.r_data),
              ((i - 1) % 2 == 1) ? 64'(32'h5000 + 32'(i - 2)) : 64'h0);
        if (tcdm.r_valid) sr++;
      end
    end
    check("st_grants", 64'(sg), 64'd64);
    check("st_rsps",   64'(sr), 64'd64);
    idle();

    // Address one past the end of the bank
    drive(1'b1, 1'b0, BASE, 32'h0BAD_F00D, 4'hF, 8'd50);
    drive(1'b1, 1'b1, BASE + 32'(4 * NW), 32'h0, 4'hF, 8'd51);
    check("ac_gnt", 64'(tcdm.gnt), 64'h1);
`ifdef HCI_MEM_ADDR_CHECK_EN
    check("ac_sram_req", 64'(sram_req), 64'h0);
`else
    check("ac_sram_req",  64'(sram_req),  64'h1);
    check("ac_sram_addr", 64'(sram_addr), 64'h0);
`endif
    idle();
    check("ac_rsp_valid", 64'(tcdm.r_valid), 64'h1);
    check("ac_rsp_id",    64'(tcdm.r_id),    64'd51);
`ifdef HCI_MEM_ADDR_CHECK_EN
    check("ac_rsp_opc",  64'(tcdm.r_opc),  64'h1);
    check("ac_rsp_data", 64'(tcdm.r_data), 64'h0);
`else
    check("ac_rsp_opc",  64'(tcdm.r_opc),  64'h0);
    check("ac_rsp_data", 64'(tcdm.r_data), 64'h0BAD_F00D);
`endif
    idle();

    // Reset with two responses outstanding
    tcdm.r_ready = 1'b0;
    drive(1'b1, 1'b1, BASE, 32'h0, 4'hF, 8'd60);
    check("mr_gnt0", 64'(tcdm.gnt), 64'h1);
    drive(1'b1, 1'b1, BASE + 32'h4, 32'h0, 4'hF, 8'd61);
    check("mr_gnt1", 64'(tcdm.gnt), 64'h1);
    idle();
    check("mr_pending_valid", 64'(tcdm.r_valid), 64'h1);
    check("mr_pending_id",    64'(tcdm.r_id),    64'd60);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mr_valid_cleared", 64'(tcdm.r_valid),             64'h0);
    check("mr_data_cleared",  64'(tcdm.r_data),              64'h0);
    check("mr_buf_empty",     64'(dut.u_resp_fifo.empty),    64'h1);
    check("mr_buf_usage",     64'(dut.u_resp_fifo.usage),    64'h0);
    tcdm.r_ready = 1'b1;
    drive(1'b1, 1'b1, BASE, 32'h0, 4'hF, 8'd62);
    check("mr_post_gnt", 64'(tcdm.gnt), 64'h1);
    idle();
    check("mr_post_id",   64'(tcdm.r_id),   64'd62);
    check("mr_post_data", 64'(tcdm.r_data), 64'h0BAD_F00D);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hci_mem_bank_adapter.md
# hci_mem_bank_adapter

Target-side HCI endpoint that terminates one `hci_core_intf` initiator and drives a single-port, 1-cycle-latency SRAM macro. It sits directly downstream of the AXI-to-HCI adapter in the TCDM path. It converts HCI req/gnt into SRAM strobes and returns exactly one response per granted request, reads and writes alike. A small response buffer honours `r_ready` backpressure without losing SRAM read data.

## Interface
- `NumWords`, 1024: SRAM depth in words; must be ≥ 2.
- `DataWidth`, 32: data width; must equal the HCI data width; multiple of 8.
- `AddrWidth`, 32: HCI byte-address width.
- `BaseAddr`, '0: byte address that maps to SRAM word 0; aligned to DataWidth/8.
- `RespDepth`, 2: response-buffer depth; must be ≥ 2.
- `clk_i`  in  1  clock; all state updates on its rising edge.
- `rst_ni`  in  1  reset; synchronous, active-low.
- `tcdm_slave`  `hci_core_intf.target`  —  HCI request/response port.
- `sram_req_o`  out  1  SRAM access strobe.
- `sram_we_o`  out  1  SRAM write enable; 1 means write.
- `sram_addr_o`  out  $clog2(NumWords)  SRAM word index.
- `sram_wdata_o`  out  DataWidth  write data.
- `sram_be_o`  out  DataWidth/8  byte enables.
- `sram_rdata_i`  in  DataWidth  read data; valid one cycle after a read strobe.

## Operation
- **Word index**: `(add - BaseAddr) >> $clog2(DataWidth/8)`, truncated to the `sram_addr_o` width.
- **Credit**: `credit = inflight_q + occupancy`, where `occupancy` is the buffer occupancy.
- **Grant**: `gnt = req & (credit < RespDepth)`.
  - Combinational; no dependency on `r_ready` or on a pop in the same cycle.
- **SRAM drive on grant**:
  - `sram_req_o = gnt`; `sram_we_o = ~wen`.
  - `sram_wdata_o = data`; `sram_be_o = be`.
- **Tag capture**: on grant, register `inflight_q = 1` together with a tag {`id`, `user`, `is_read`, `err`}.
- **Response source**:
  - If `inflight_q` and the buffer is empty, the response is presented directly: `r_data = is_read ? sram_rdata_i : '0`, plus the tag fields.
  - Otherwise the head of the buffer is presented.
  - In both cases `r_valid = inflight_q | ~empty`.
- **Buffer push**: the in-flight response is pushed into the buffer when it is not consumed this cycle, i.e. the buffer is non-empty or `r_ready` = 0.
- **Buffer pop**: on `r_valid & r_ready` when the buffer is non-empty.
- **Ordering**: responses are strictly in request order.
- **`r_opc`**: `err` bit, 0 = OK, 1 = error.
- **`r_id` / `r_user`**: echo the request's `id` / `user`.
- **ECC side**: `egnt = 0`, `r_evalid = 0`, `r_ecc = '0`; `ereq` and `r_eready` are ignored.
- **Capacity**: the credit rule guarantees the buffer never overflows; an overflow push is an assertion failure.

## Timing
- **Reset values**:
  - `gnt = 0` and `r_valid = 0`.
  - `r_data`, `r_id`, `r_user`, `r_opc` = '0.
  - `sram_req_o = 0`, `sram_we_o = 0`.
- **Latency**: grant in cycle N → `r_valid` in cycle N+1 (zero-wait when `r_ready` = 1).
- **Throughput**: one request per cycle sustained while `r_ready` = 1, with RespDepth = 2.
- **Stall**: with `r_ready` held 0, at most RespDepth requests are granted; `gnt` then stays 0 until a pop.
- **Handshake**: `r_valid` must not drop, and the presented response must stay stable, until accepted.
- **Simultaneous push and pop**: occupancy is unchanged; FIFO order is kept.
- **Reset mid-operation**: `inflight_q` and the buffer are cleared; outstanding responses are dropped. The initiator is reset in the same domain.

## Configuration
- **`HCI_MEM_ADDR_CHECK_EN` defined**:
  - A request with `add < BaseAddr` or word index ≥ NumWords is still granted, but `sram_req_o` stays 0 (no write side effect).
  - Its response has `r_opc = 1` and `r_data = '0`.
- **`HCI_MEM_ADDR_CHECK_EN` undefined**:
  - No check; the word index wraps modulo 2^$clog2(NumWords).
  - `r_opc` is always 0.

## Structure
- **Package `hci_mem_pkg`**:
  - `HCI_OPC_OK = 1'b0` and `HCI_OPC_ERR = 1'b1`.
  - Function `word_idx(add, base, data_width)`.
- **Response struct**: parameter-dependent, so declared inside the module.
- **Sub-module `hci_mem_resp_fifo`**:
  - Depth RespDepth, synchronous active-low reset.
  - Outputs `full`, `empty` and `usage`.

## Test plan
- **Single access**: write `0xDEADBEEF`, be=`0xF`, to BaseAddr+0x10, then read the same address. → SRAM word 4 written; read `r_valid` one cycle after grant with `r_data = 0xDEADBEEF`, `r_opc = 0`.
- **Byte enables**: write `0x11223344`, be=`0x5`, over stored `0xFFFFFFFF`, then read back. → `0xFF22FF44`.
- **Backpressure**: 5 back-to-back reads with `r_ready` = 0. → exactly 2 grants; `gnt = 0` afterwards. Releasing `r_ready` → responses come out in order with the correct ids, and the remaining 3 requests are granted.
- **Streaming**: 64 alternating reads and writes with `r_ready` = 1. → one grant per cycle, every response 1 cycle after its grant, 64 responses total.
- **Address check**: read at BaseAddr + 4·NumWords. → with the macro: `r_opc = 1`, `r_data = 0`, no SRAM strobe. Without the macro: word 0 is returned.
- **Reset mid-operation**: assert `rst_ni` = 0 for one cycle while 2 responses are pending. → next cycle `r_valid = 0` and the buffer is empty.
